mdu_seq: RTL and testbench
==========================

# mdu_seq

Multi-cycle multiply/divide sequencer for the execute stage. It decodes the multiply/divide subset of `alucontrol` and drives an external pipelined multiplier and an internal iterative divider. It stalls the pipeline until the result is ready, then hands HI/LO (or the `MUL` GPR result) to writeback exactly once. Single-cycle ALU ops bypass it entirely.

## Interface
Parameters:
- `MUL_LAT`, default 3: latency of the external multiplier, in cycles (1..7).
- `DIV_SIGN_FIX`, default 1: 1 enables signed fix-up for `DIV`. 0 is test-only (forces unsigned).

Ports:
- `clk` in 1: clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `alucontrol` in 8: op from the ALU decoder. The block acts only on `MULT`, `MULTU`, `DIV`, `DIVU`, `MUL`, `MADD`, `MADDU`, `MSUB`, `MSUBU` (`_CONTROL` codes).
- `a`, `b` in 32 each: rs and rt operands, sampled at accept.
- `hi_in`, `lo_in` in 32 each: current HI/LO, sampled at accept for accumulate ops.
- `stallE` in 1: execute stage held by another source.
- `flushE` in 1: cancel the in-flight op (exception or branch).
- `mul_p` in 64: external multiplier product, valid `MUL_LAT` cycles after `mul_start`.
- `mul_start` out 1: one-cycle start pulse to the multiplier.
- `mul_signed` out 1: signed-multiply select.
- `mul_a`, `mul_b` out 32 each: registered operands to the multiplier.
- `stall_req` out 1: hold the pipeline.
- `done` out 1: result valid, one cycle.
- `hilo_we` out 1: write HI/LO this cycle.
- `gpr_we` out 1: `MUL` result to rd this cycle.
- `hi_out`, `lo_out` out 32 each: result.

## Operation
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- **IDLE:** an MDU op present with `!flushE` is accepted.
  - Accept asserts `stall_req` combinationally in the same cycle. Operands, op class and accumulator are latched.
  - Multiply class: `mul_start`=1 for one cycle, cycle counter loaded with `MUL_LAT`, go to MUL_WAIT.
  - Divide class: load the divider, go to DIV_RUN.
- **MUL_WAIT:** counter decrements each cycle. At 0, capture `mul_p` and go to DONE.
  - `MADD`/`MADDU`: {hi,lo} = acc + p, 64-bit wrap.
  - `MSUB`/`MSUBU`: {hi,lo} = acc − p, 64-bit wrap.
  - `MUL`: lo = p[31:0], hi unchanged.
- **DIV_RUN:** radix-2 restoring divider, 32 iterations, one per cycle, operating on magnitudes.
  - Signed fix-up: quotient sign = a[31]^b[31]; remainder takes the sign of a.
  - Result: lo = quotient, hi = remainder.
  - Divide by zero (b=0): skip iterations, go straight to DONE with lo=32'hFFFF_FFFF, hi=a.
- **DONE:** `done`=1. `hilo_we`=1, or `gpr_we`=1 for `MUL`.
  - `stall_req`=0 in this cycle, so the op retires.
  - If `stallE`=1, hold DONE with `done`/`*_we` deasserted and `stall_req`=0. Re-assert `done`/`*_we` for the first cycle with `stallE`=0, then go to IDLE.
  - Writes occur exactly once per op.
- **Flush:** `flushE` in any non-IDLE state returns to IDLE next cycle with no write. An in-flight multiplier result is ignored.
- **Re-issue guard:** in DONE the same `alucontrol` is still present; the block must not re-accept it. Re-accept is allowed only from IDLE.

## Timing
- Reset values: state=IDLE; all outputs 0; internal registers 0.
- Multiply latency: accept cycle T, `done` at T+`MUL_LAT`+1. `stall_req` is high in cycles T..T+`MUL_LAT`.
- Divide latency: `done` at T+33. Divide by zero: `done` at T+2.
- `flushE` and the DONE cycle together: flush wins, no write.
- `resetn` low mid-operation: IDLE immediately (asynchronous). No write, `mul_start` low.
- `hi_out`/`lo_out` are stable from entry to DONE until the next accept.

## Structure
- Op-class decode uses the shared `_CONTROL` codes from `defines.h`. State encodings are local localparams.
- Sub-module `div_iter` holds the 32-step restoring core: `start`/`busy`/`done`, with dividend, divisor, quotient and remainder.
- Multiplier stays external.

## Test plan
- `MULT` a=−3 (32'hFFFF_FFFD), b=7, `MUL_LAT`=3 → `done` 4 cycles after accept, hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB, `hilo_we`=1 once.
- `DIVU` a=100, b=7 → `done` at T+33, lo=14, hi=2. `DIV` a=−7, b=2 → lo=−3, hi=−1.
- `DIV` a=5, b=0 → `done` at T+2, lo=32'hFFFF_FFFF, hi=5.
- `MADDU` with hi_in=0, lo_in=32'hFFFF_FFFF, a=1, b=1 → hi=1, lo=0. `MUL` 6×7 → `gpr_we`=1, lo=42, `hilo_we`=0.
- `flushE` pulsed at DIV_RUN cycle 10 → IDLE next cycle, no `done`, no write. A new `DIVU` is accepted the following cycle.
- `stallE` held 3 cycles across DONE → a single `done`/`hilo_we` pulse in the cycle `stallE` falls. No second accept of the held op.

Source files
------------

// File: rtl/mdu_seq_pkg.sv
// Shared op codes, state/op-class types and small decode helpers for the
// multiply/divide sequencer.
package mdu_seq_pkg;

   localparam logic [7:0] MULT_CONTROL  = 8'h30;
   localparam logic [7:0] MULTU_CONTROL = 8'h31;
   localparam logic [7:0] DIV_CONTROL   = 8'h32;
   localparam logic [7:0] DIVU_CONTROL  = 8'h33;
   localparam logic [7:0] MUL_CONTROL   = 8'h34;
   localparam logic [7:0] MADD_CONTROL  = 8'h35;
   localparam logic [7:0] MADDU_CONTROL = 8'h36;
   localparam logic [7:0] MSUB_CONTROL  = 8'h37;
   localparam logic [7:0] MSUBU_CONTROL = 8'h38;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_MUL_WAIT = 2'd1,
      S_DIV_RUN  = 2'd2,
      S_DONE     = 2'd3
   } state_e;

   typedef enum logic [2:0] {
      C_NONE = 3'd0,
      C_MULT = 3'd1,
      C_MUL  = 3'd2,
      C_MADD = 3'd3,
      C_MSUB = 3'd4,
      C_DIV  = 3'd5
   } op_class_e;

   function automatic op_class_e op_class(input logic [7:0] op);
      op_class_e c;
      case (op)
         MULT_CONTROL, MULTU_CONTROL: c = C_MULT;
         MUL_CONTROL:                 c = C_MUL;
         MADD_CONTROL, MADDU_CONTROL: c = C_MADD;
         MSUB_CONTROL, MSUBU_CONTROL: c = C_MSUB;
         DIV_CONTROL, DIVU_CONTROL:   c = C_DIV;
         default:                     c = C_NONE;
      endcase
      return c;
   endfunction

   function automatic logic op_signed(input logic [7:0] op);
      logic s;
      case (op)
         MULT_CONTROL, MUL_CONTROL, MADD_CONTROL,
         MSUB_CONTROL, DIV_CONTROL: s = 1'b1;
         default:                   s = 1'b0;
      endcase
      return s;
   endfunction

   function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
      return n ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/mdu_seq_div_iter.sv
// Radix-2 restoring divider core on unsigned magnitudes: one quotient bit per
// cycle over 32 cycles; quo_o/rem_o show the step being completed this cycle.
module mdu_seq_div_iter (
   input  logic        clk,
   input  logic        resetn,
   input  logic        start_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] quo_o,
   output logic [31:0] rem_o
);

   logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        busy_q, busy_d;
   logic [32:0] shifted_s, diff_s;
   logic        qbit_s;
   logic [31:0] quo_step_s, rem_step_s;

   // 33-bit trial subtraction: the shifted partial remainder can exceed 32 bits
   assign shifted_s  = {rem_q, quo_q[31]};
   assign diff_s     = shifted_s - {1'b0, dvs_q};
   assign qbit_s     = ~diff_s[32];
   assign rem_step_s = qbit_s ? diff_s[31:0] : shifted_s[31:0];
   assign quo_step_s = {quo_q[30:0], qbit_s};

   always_comb begin
      quo_d  = quo_q;
      rem_d  = rem_q;
      dvs_d  = dvs_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start_i) begin
         quo_d  = dividend_i;
         rem_d  = 32'd0;
         dvs_d  = divisor_i;
         cnt_d  = 6'd32;
         busy_d = 1'b1;
      end else if (busy_q) begin
         quo_d  = quo_step_s;
         rem_d  = rem_step_s;
         cnt_d  = cnt_q - 6'd1;
         busy_d = (cnt_q != 6'd1);
      end else begin
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         quo_q  <= 32'd0;
         rem_q  <= 32'd0;
         dvs_q  <= 32'd0;
         cnt_q  <= 6'd0;
         busy_q <= 1'b0;
      end else begin
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy_o = busy_q;
   assign done_o = busy_q && (cnt_q == 6'd1);
   assign quo_o  = quo_step_s;
   assign rem_o  = rem_step_s;

endmodule

// File: rtl/mdu_seq.sv
// Execute-stage multiply/divide sequencer: drives an external pipelined
// multiplier and an internal iterative divider, stalls, then writes back once.
module mdu_seq
   import mdu_seq_pkg::*;
#(
   parameter int MUL_LAT      = 3,
   parameter bit DIV_SIGN_FIX = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [7:0]  alucontrol,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] hi_in,
   input  logic [31:0] lo_in,
   input  logic        stallE,
   input  logic        flushE,
   input  logic [63:0] mul_p,
   output logic        mul_start,
   output logic        mul_signed,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        stall_req,
   output logic        done,
   output logic        hilo_we,
   output logic        gpr_we,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   state_e      state_q, state_d;
   op_class_e   cls_q, cls_d, cls_in_s;
   logic [31:0] a_q, a_d, b_q, b_d, acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        sgn_q, sgn_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
   logic        sgn_in_s, sdiv_s, accept_s, div_start_s, wr_s;
   logic        div_busy_s, div_done_s;
   logic [31:0] dvd_mag_s, dvs_mag_s, quo_s, rem_s;
   logic [63:0] acc_s;

   assign cls_in_s    = op_class(alucontrol);
   assign sgn_in_s    = op_signed(alucontrol);
   assign sdiv_s      = sgn_in_s && (cls_in_s == C_DIV) && DIV_SIGN_FIX;
   // Gated by resetn so nothing is started while reset is held
   assign accept_s    = resetn && (state_q == S_IDLE) && (cls_in_s != C_NONE) && !flushE;
   assign div_start_s = accept_s && (cls_in_s == C_DIV) && (b != 32'd0);
   assign dvd_mag_s   = neg_if(sdiv_s && a[31], a);
   assign dvs_mag_s   = neg_if(sdiv_s && b[31], b);
   assign acc_s       = {acc_hi_q, acc_lo_q};

   mdu_seq_div_iter u_div_iter (
      .clk        (clk),
      .resetn     (resetn),
      .start_i    (div_start_s),
      .dividend_i (dvd_mag_s),
      .divisor_i  (dvs_mag_s),
      .busy_o     (div_busy_s),
      .done_o     (div_done_s),
      .quo_o      (quo_s),
      .rem_o      (rem_s)
   );

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      a_d       = a_q;
      b_d       = b_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      sgn_d     = sgn_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      dz_d      = dz_q;
      case (state_q)
         S_IDLE: begin
            if (accept_s) begin
               cls_d     = cls_in_s;
               a_d       = a;
               b_d       = b;
               acc_hi_d  = hi_in;
               acc_lo_d  = lo_in;
               sgn_d     = sgn_in_s;
               neg_quo_d = sdiv_s && (a[31] ^ b[31]);
               neg_rem_d = sdiv_s && a[31];
               dz_d      = (b == 32'd0);
               if (cls_in_s == C_DIV) begin
                  state_d = S_DIV_RUN;
               end else begin
                  cnt_d   = 3'(MUL_LAT);
                  state_d = S_MUL_WAIT;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_MUL_WAIT: begin
            if (flushE) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 3'd1;
               // Counter reaches zero on this edge: the product is valid now
               if (cnt_q == 3'd1) begin
                  state_d = S_DONE;
                  case (cls_q)
                     C_MADD:  {hi_d, lo_d} = acc_s + mul_p;
                     C_MSUB:  {hi_d, lo_d} = acc_s - mul_p;
                     C_MUL:   {hi_d, lo_d} = {acc_hi_q, mul_p[31:0]};
                     default: {hi_d, lo_d} = mul_p;
                  endcase
               end else begin
                  state_d = S_MUL_WAIT;
               end
            end
         end
         S_DIV_RUN: begin
            if (flushE) begin
               state_d = S_IDLE;
            end else if (dz_q) begin
               hi_d    = a_q;
               lo_d    = 32'hFFFF_FFFF;
               state_d = S_DONE;
            end else if (div_busy_s && div_done_s) begin
               hi_d    = neg_if(neg_rem_q, rem_s);
               lo_d    = neg_if(neg_quo_q, quo_s);
               state_d = S_DONE;
            end else begin
               state_d = S_DIV_RUN;
            end
         end
         S_DONE: begin
            if (flushE || !stallE) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_IDLE;
         cls_q     <= C_NONE;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         acc_hi_q  <= 32'd0;
         acc_lo_q  <= 32'd0;
         hi_q      <= 32'd0;
         lo_q      <= 32'd0;
         cnt_q     <= 3'd0;
         sgn_q     <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         a_q       <= a_d;
         b_q       <= b_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         sgn_q     <= sgn_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         dz_q      <= dz_d;
      end
   end

   // Operands bypass to the multiplier in the accept cycle, then hold latched
   assign mul_start  = accept_s && (cls_in_s != C_DIV);
   assign mul_signed = accept_s ? sgn_in_s : sgn_q;
   assign mul_a      = accept_s ? a : a_q;
   assign mul_b      = accept_s ? b : b_q;
   assign stall_req  = accept_s || (state_q == S_MUL_WAIT) || (state_q == S_DIV_RUN);
   assign wr_s       = (state_q == S_DONE) && !stallE && !flushE;
   assign done       = wr_s;
   assign hilo_we    = wr_s && (cls_q != C_MUL);
   assign gpr_we     = wr_s && (cls_q == C_MUL);
   assign hi_out     = hi_q;
   assign lo_out     = lo_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: directed and random ops against an
// arithmetic reference model, with a behavioural pipelined multiplier.
module tb_mdu_seq;
   import mdu_seq_pkg::*;

   localparam int LAT = 3;
   localparam logic [7:0] NOP = 8'h00;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  alucontrol;
   logic [31:0] a, b, hi_in, lo_in;
   logic        stallE, flushE;
   logic [63:0] mul_p;
   logic        mul_start, mul_signed, stall_req, done, hilo_we, gpr_we;
   logic [31:0] mul_a, mul_b, hi_out, lo_out;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] prev_hi, prev_lo;
   logic [63:0] pipe [LAT];

   mdu_seq #(.MUL_LAT(LAT), .DIV_SIGN_FIX(1'b1)) dut (
      .clk(clk), .resetn(resetn), .alucontrol(alucontrol), .a(a), .b(b),
      .hi_in(hi_in), .lo_in(lo_in), .stallE(stallE), .flushE(flushE),
      .mul_p(mul_p), .mul_start(mul_start), .mul_signed(mul_signed),
      .mul_a(mul_a), .mul_b(mul_b), .stall_req(stall_req), .done(done),
      .hilo_we(hilo_we), .gpr_we(gpr_we), .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] prod64(input logic [31:0] x, input logic [31:0] y, input logic sgn);
      longint sx, sy;
      if (sgn) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
      end else begin
         sx = longint'({32'd0, x});
         sy = longint'({32'd0, y});
      end
      return 64'(sx * sy);
   endfunction

   // External multiplier: product appears LAT cycles after the start cycle
   always @(posedge clk) begin
      pipe[0] <= mul_start ? prod64(mul_a, mul_b, mul_signed) : 64'hDEAD_BEEF_DEAD_BEEF;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign mul_p = pipe[LAT-1];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic ref_op(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] h, input logic [31:0] l,
                         output logic [31:0] eh, output logic [31:0] el,
                         output int lat, output bit gpr);
      logic [63:0] acc, p;
      longint sx, sy;
      acc = {h, l};
      gpr = 1'b0;
      lat = LAT + 1;
      eh  = 32'd0;
      el  = 32'd0;
      case (op)
         MULT_CONTROL:  {eh, el} = prod64(x, y, 1'b1);
         MULTU_CONTROL: {eh, el} = prod64(x, y, 1'b0);
         MADD_CONTROL:  {eh, el} = acc + prod64(x, y, 1'b1);
         MADDU_CONTROL: {eh, el} = acc + prod64(x, y, 1'b0);
         MSUB_CONTROL:  {eh, el} = acc - prod64(x, y, 1'b1);
         MSUBU_CONTROL: {eh, el} = acc - prod64(x, y, 1'b0);
         MUL_CONTROL: begin
            p   = prod64(x, y, 1'b1);
            eh  = h;
            el  = p[31:0];
            gpr = 1'b1;
         end
         DIV_CONTROL, DIVU_CONTROL: begin
            if (y == 32'd0) begin
               eh  = x;
               el  = 32'hFFFF_FFFF;
               lat = 2;
            end else begin
               lat = 33;
               if (op == DIV_CONTROL) begin
                  sx = longint'($signed(x));
                  sy = longint'($signed(y));
                  el = 32'(sx / sy);
                  eh = 32'(sx % sy);
               end else begin
                  el = x / y;
                  eh = x % y;
               end
            end
         end
         default: begin
            eh = 32'd0;
            el = 32'd0;
         end
      endcase
   endtask

   // Issue one op; stallE covers stall_n cycles from DONE entry; flush_at<0 means no flush
   task automatic do_op(input logic [7:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] h, input logic [31:0] l,
                        input int stall_n, input int flush_at);
      logic [31:0] eh, el;
      int lat, k;
      bit gpr, is_div;
      ref_op(op, x, y, h, l, eh, el, lat, gpr);
      is_div = (op == DIV_CONTROL) || (op == DIVU_CONTROL);
      @(negedge clk);
      alucontrol = op; a = x; b = y; hi_in = h; lo_in = l; stallE = 1'b0; flushE = 1'b0;
      #1;
      chk("acc_stall", 64'(stall_req), 64'(1'b1));
      chk("acc_mstart", 64'(mul_start), 64'(!is_div));
      k = 0;
      forever begin
         @(negedge clk);
         k++;
         stallE = (k >= lat) && (k < lat + stall_n);
         flushE = (k == flush_at);
         #1;
         if (flushE) begin
            chk("flush_done", 64'(done), 64'(1'b0));
            chk("flush_we", 64'(hilo_we | gpr_we), 64'(1'b0));
            if (k < lat) begin
               chk("flush_hi", 64'(hi_out), 64'(prev_hi));
               chk("flush_lo", 64'(lo_out), 64'(prev_lo));
            end else begin
               prev_hi = eh;
               prev_lo = el;
            end
            return;
         end
         if (stallE) begin
            chk("hold_done", 64'(done), 64'(1'b0));
            chk("hold_stall", 64'(stall_req), 64'(1'b0));
            chk("hold_mstart", 64'(mul_start), 64'(1'b0));
         end
         if (done || k > 80) break;
      end
      chk("latency", 64'(k), 64'(lat + stall_n));
      chk("hi", 64'(hi_out), 64'(eh));
      chk("lo", 64'(lo_out), 64'(el));
      chk("hilo_we", 64'(hilo_we), 64'(!gpr));
      chk("gpr_we", 64'(gpr_we), 64'(gpr));
      prev_hi = eh;
      prev_lo = el;
      @(negedge clk);
      alucontrol = NOP; stallE = 1'b0;
      #1;
      chk("single_done", 64'(done), 64'(1'b0));
      chk("no_reaccept", 64'(stall_req), 64'(1'b0));
   endtask

   initial begin
      logic [7:0] ops [9];
      logic [31:0] rx, ry;
      int sel;
      ops = '{MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL, MUL_CONTROL,
              MADD_CONTROL, MADDU_CONTROL, MSUB_CONTROL, MSUBU_CONTROL};

      // Reset with an op present: nothing may start
      resetn = 1'b0; alucontrol = MULT_CONTROL; a = 32'd5; b = 32'd6;
      hi_in = 32'd0; lo_in = 32'd0; stallE = 1'b0; flushE = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_stall", 64'(stall_req), 64'(1'b0));
      chk("rst_mstart", 64'(mul_start), 64'(1'b0));
      chk("rst_done", 64'(done), 64'(1'b0));
      chk("rst_we", 64'({hilo_we, gpr_we}), 64'(2'b00));
      chk("rst_hilo", {hi_out, lo_out}, 64'd0);
      chk("rst_mula", 64'(mul_a), 64'd0);
      @(negedge clk);
      alucontrol = NOP; resetn = 1'b1;
      prev_hi = 32'd0; prev_lo = 32'd0;

      do_op(MULT_CONTROL,  32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, 0, -1);
      do_op(DIVU_CONTROL,  32'd100, 32'd7, 32'd0, 32'd0, 0, -1);
      do_op(DIV_CONTROL,   32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 0, -1);
      do_op(DIV_CONTROL,   32'd5, 32'd0, 32'd0, 32'd0, 0, -1);
      do_op(MADDU_CONTROL, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, -1);
      do_op(MUL_CONTROL,   32'd6, 32'd7, 32'h1234_5678, 32'h9ABC_DEF0, 0, -1);
      do_op(DIVU_CONTROL,  32'd1000, 32'd3, 32'd0, 32'd0, 0, 10);
      do_op(DIVU_CONTROL,  32'hFFFF_FFFF, 32'd16, 32'd0, 32'd0, 0, -1);
      do_op(MULT_CONTROL,  32'd123, 32'hFFFF_FE38, 32'd0, 32'd0, 3, -1);
      do_op(MSUB_CONTROL,  32'd9, 32'd9, 32'd1, 32'd2, 0, LAT + 1);
      do_op(MSUBU_CONTROL, 32'd2, 32'd3, 32'd0, 32'd5, 0, -1);
      do_op(DIV_CONTROL,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, -1);
      do_op(DIV_CONTROL,   32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 1, -1);

      // Asynchronous reset in the middle of a divide
      @(negedge clk);
      alucontrol = DIVU_CONTROL; a = 32'd50; b = 32'd3;
      @(negedge clk);
      alucontrol = NOP;
      repeat (4) @(negedge clk);
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_stall", 64'(stall_req), 64'(1'b0));
      chk("mid_rst_hilo", {hi_out, lo_out}, 64'd0);
      chk("mid_rst_mstart", 64'(mul_start), 64'(1'b0));
      chk("mid_rst_done", 64'(done), 64'(1'b0));
      @(negedge clk);
      resetn = 1'b1;
      prev_hi = 32'd0; prev_lo = 32'd0;

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 3);
         rx  = $urandom;
         ry  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'($urandom_range(1, 15)) : $urandom;
         do_op(ops[$urandom_range(0, 8)], rx, ry, $urandom, $urandom,
               $urandom_range(0, 2),
               ($urandom_range(0, 6) == 0) ? $urandom_range(1, 4) : -1);
      end

      @(negedge clk);
      flushE = 1'b0; stallE = 1'b0; alucontrol = NOP;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
